// File: rtl/gray_pkg.sv
// gray_pkg: shared Gray/binary helpers, FSM state type and limits for gray_ptr_sync.
package gray_pkg;
   localparam int MIN_SYNC_STAGES = 2;
   localparam int GRAY_MAX_W = 32;
   typedef enum logic {INIT, RUN} state_e;
   // Zero-extended inputs convert correctly, so callers cast to and from their own width.
   function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
      logic [GRAY_MAX_W-1:0] b;
      b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
      for (int i = GRAY_MAX_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction
   function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
      return b ^ (b >> 1);
   endfunction
endpackage

// File: rtl/gray_sync_chain.sv
// gray_sync_chain: bare multi-flop synchronizer for a Gray-coded bus, no logic between stages.
module gray_sync_chain #(
   parameter int SIZE = 10,
   parameter int SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [SIZE-1:0] d_i,
   output logic [SIZE-1:0] q_o
);
   logic [SIZE-1:0] sync_q [SYNC_STAGES];
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= d_i;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end
   assign q_o = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/gray_ptr_sync.sv
// gray_ptr_sync: synchronizes a foreign-domain Gray pointer, converts it to binary,
// reports per-update delta and flags illegal multi-bit Gray transitions.
module gray_ptr_sync
   import gray_pkg::*;
#(
   parameter int SIZE = 10,
   parameter int SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [SIZE-1:0] gray_in,
   input  logic            err_clr,
   output logic [SIZE-1:0] gray_out,
   output logic [SIZE-1:0] bin_out,
   output logic [SIZE-1:0] delta,
   output logic            changed,
   output logic            err
);
   localparam int STAGES = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;
   localparam int CW = $clog2(STAGES + 1);
   state_e state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [SIZE-1:0] g_s, bin_s, x;
   logic [SIZE-1:0] gray_q, gray_d, bin_q, bin_d, delta_q, delta_d;
   logic changed_q, changed_d, err_q, err_d;
   gray_sync_chain #(.SIZE(SIZE), .SYNC_STAGES(STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .d_i (gray_in),
      .q_o (g_s)
   );
   always_comb begin
      bin_s = SIZE'(gray2bin(GRAY_MAX_W'(g_s)));
      x = g_s ^ gray_q;
      state_d = state_q;
      cnt_d = cnt_q;
      gray_d = gray_q;
      bin_d = bin_q;
      delta_d = '0;
      changed_d = 1'b0;
      err_d = err_clr ? 1'b0 : err_q;
      if (state_q == INIT) begin
         // Wait for the chain to fill with post-reset samples; the priming load is not an update.
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == CW'(STAGES)) begin
            state_d = RUN;
            gray_d = g_s;
            bin_d = bin_s;
         end
      end else if (x != '0) begin
         gray_d = g_s;
         bin_d = bin_s;
         delta_d = bin_s - bin_q;
         changed_d = 1'b1;
         err_d = ((x & (x - SIZE'(1))) != '0) ? 1'b1 : err_d;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= INIT;
         cnt_q <= '0;
         gray_q <= '0;
         bin_q <= '0;
         delta_q <= '0;
         changed_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         gray_q <= gray_d;
         bin_q <= bin_d;
         delta_q <= delta_d;
         changed_q <= changed_d;
         err_q <= err_d;
      end
   end
   assign gray_out = gray_q;
   assign bin_out = bin_q;
   assign delta = delta_q;
   assign changed = changed_q;
   assign err = err_q;
endmodule

// File: tb/tb_gray_ptr_sync.sv
// tb_gray_ptr_sync: directed bench for gray_ptr_sync (SIZE=10, SYNC_STAGES=2).
module tb_gray_ptr_sync;
   import gray_pkg::*;
   logic clk, rst, err_clr, changed, err;
   logic [9:0] gray_in, gray_out, bin_out, delta;
   int checks = 0;
   int failures = 0;
   int pulses;
   logic [9:0] cap_bin, cap_delta;
   gray_ptr_sync #(.SIZE(10), .SYNC_STAGES(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .gray_in  (gray_in),
      .err_clr  (err_clr),
      .gray_out (gray_out),
      .bin_out  (bin_out),
      .delta    (delta),
      .changed  (changed),
      .err      (err)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   // Apply a Gray value and watch four edges, recording the update pulse.
   task automatic drive_gray(input logic [9:0] g);
      gray_in = g;
      pulses = 0;
      cap_bin = '0;
      cap_delta = '0;
      for (int i = 0; i < 4; i++) begin
         cyc();
         if (changed) begin
            pulses++;
            cap_bin = bin_out;
            cap_delta = delta;
         end
      end
   endtask
   task automatic reset_to(input logic [9:0] g);
      rst = 1'b1;
      gray_in = g;
      repeat (2) cyc();
      rst = 1'b0;
      repeat (4) cyc();
   endtask
   task automatic test_reset();
      rst = 1'b1;
      err_clr = 1'b0;
      gray_in = 10'h00F;
      repeat (3) cyc();
      checks++;
      if ({gray_out, bin_out, delta, changed, err} !== 32'h0) begin
         failures++;
         $display("FAIL reset_state: got gray=%h bin=%h delta=%h chg=%b err=%b expected all zero", gray_out, bin_out, delta, changed, err);
      end
      rst = 1'b0;
      for (int e = 1; e <= 2; e++) begin
         cyc();
         checks++;
         if ({gray_out, bin_out, changed} !== 21'h0) begin
            failures++;
            $display("FAIL init_hold edge%0d: got gray=%h bin=%h chg=%b expected 000 000 0", e, gray_out, bin_out, changed);
         end
      end
      cyc();
      checks++;
      if (gray_out !== 10'h00F || bin_out !== 10'h00A || changed !== 1'b0 || delta !== 10'h000 || err !== 1'b0) begin
         failures++;
         $display("FAIL priming_load: got gray=%h bin=%h chg=%b delta=%h err=%b expected 00f 00a 0 000 0", gray_out, bin_out, changed, delta, err);
      end
   endtask
   task automatic test_count();
      reset_to(10'h000);
      for (int n = 1; n <= 1024; n++) begin
         drive_gray(10'(bin2gray(32'(n % 1024))));
         checks++;
         if (pulses != 1 || cap_bin !== 10'(n % 1024) || cap_delta !== 10'h001) begin
            failures++;
            $display("FAIL count_step n=%0d: got pulses=%0d bin=%h delta=%h expected pulses=1 bin=%h delta=001", n, pulses, cap_bin, cap_delta, 10'(n % 1024));
         end
      end
      checks++;
      if (err !== 1'b0) begin
         failures++;
         $display("FAIL count_err: got %b expected 0", err);
      end
   endtask
   task automatic test_down();
      drive_gray(10'h001);
      drive_gray(10'h003);
      drive_gray(10'h002);
      drive_gray(10'h006);
      drive_gray(10'h007);
      drive_gray(10'h006);
      checks++;
      if (pulses != 1 || cap_bin !== 10'h004 || cap_delta !== 10'h3FF || err !== 1'b0) begin
         failures++;
         $display("FAIL down_step: got pulses=%0d bin=%h delta=%h err=%b expected 1 004 3ff 0", pulses, cap_bin, cap_delta, err);
      end
   endtask
   task automatic test_multibit();
      drive_gray(10'h002);
      drive_gray(10'h003);
      drive_gray(10'h001);
      drive_gray(10'h000);
      checks++;
      if (err !== 1'b0) begin
         failures++;
         $display("FAIL pre_jump_err: got %b expected 0", err);
      end
      drive_gray(10'h003);
      checks++;
      if (pulses != 1 || cap_bin !== 10'h002 || cap_delta !== 10'h002 || err !== 1'b1) begin
         failures++;
         $display("FAIL jump: got pulses=%0d bin=%h delta=%h err=%b expected 1 002 002 1", pulses, cap_bin, cap_delta, err);
      end
      for (int i = 0; i < 20; i++) begin
         cyc();
         checks++;
         if (err !== 1'b1 || changed !== 1'b0) begin
            failures++;
            $display("FAIL err_sticky cycle%0d: got err=%b chg=%b expected 1 0", i, err, changed);
         end
      end
   endtask
   task automatic test_err_clr();
      drive_gray(10'h001);
      drive_gray(10'h000);
      err_clr = 1'b1;
      cyc();
      err_clr = 1'b0;
      checks++;
      if (err !== 1'b0) begin
         failures++;
         $display("FAIL err_clr_alone: got %b expected 0", err);
      end
      gray_in = 10'h005;
      cyc();
      cyc();
      checks++;
      if (err !== 1'b0 || changed !== 1'b0) begin
         failures++;
         $display("FAIL before_collide: got err=%b chg=%b expected 0 0", err, changed);
      end
      err_clr = 1'b1;
      cyc();
      err_clr = 1'b0;
      checks++;
      if (err !== 1'b1 || changed !== 1'b1 || bin_out !== 10'h006 || delta !== 10'h006) begin
         failures++;
         $display("FAIL set_wins: got err=%b chg=%b bin=%h delta=%h expected 1 1 006 006", err, changed, bin_out, delta);
      end
   endtask
   task automatic test_midreset();
      drive_gray(10'h108);
      checks++;
      if (bin_out !== 10'h1F0 || err !== 1'b1) begin
         failures++;
         $display("FAIL pre_reset: got bin=%h err=%b expected 1f0 1", bin_out, err);
      end
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      checks++;
      if ({gray_out, bin_out, delta, changed, err} !== 32'h0) begin
         failures++;
         $display("FAIL midreset_clear: got gray=%h bin=%h delta=%h chg=%b err=%b expected all zero", gray_out, bin_out, delta, changed, err);
      end
      for (int e = 1; e <= 2; e++) begin
         cyc();
         checks++;
         if (gray_out !== 10'h000 || changed !== 1'b0) begin
            failures++;
            $display("FAIL reinit_hold edge%0d: got gray=%h chg=%b expected 000 0", e, gray_out, changed);
         end
      end
      cyc();
      checks++;
      if (gray_out !== 10'h108 || bin_out !== 10'h1F0 || changed !== 1'b0 || delta !== 10'h000 || err !== 1'b0) begin
         failures++;
         $display("FAIL reprime: got gray=%h bin=%h chg=%b delta=%h err=%b expected 108 1f0 0 000 0", gray_out, bin_out, changed, delta, err);
      end
   endtask
   initial begin
      test_reset();
      test_count();
      test_down();
      test_multibit();
      test_err_clr();
      test_midreset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
